// File: rtl/matrix_column_scanner.sv
// matrix_column_scanner: time-multiplexed 5x7 LED matrix column scanner with per-slot row blanking
module matrix_column_scanner #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] col_0,
    input  logic [6:0] col_1,
    input  logic [6:0] col_2,
    input  logic [6:0] col_3,
    input  logic [6:0] col_4,
    output logic [4:0] col_sel,
    output logic [6:0] row_n,
    output logic [2:0] col_idx,
    output logic       frame_start
);
    localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLAST   = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam bit            NOBLANK = (BLANK_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2:0]    r_idx, w_idx;
    logic [4:0]    r_sel, w_sel;
    logic [6:0]    r_row, w_row;
    logic          r_fs, w_fs;
    logic [6:0]    r_sh [5];
    logic          w_cap;
    logic          w_wrap;
    logic [2:0]    w_nidx;
    logic [6:0]    w_cur;
    logic [6:0]    w_nxt;

    assign w_wrap = (r_idx == 3'd4);
    assign w_nidx = w_wrap ? 3'd0 : r_idx + 3'd1;
    assign w_cur  = (r_idx == 3'd0) ? r_sh[0] :
                    (r_idx == 3'd1) ? r_sh[1] :
                    (r_idx == 3'd2) ? r_sh[2] :
                    (r_idx == 3'd3) ? r_sh[3] : r_sh[4];
    // at a frame wrap the shadow is being reloaded on the same edge, so the live input is the pattern
    assign w_nxt  = w_wrap          ? col_0   :
                    (w_nidx == 3'd1) ? r_sh[1] :
                    (w_nidx == 3'd2) ? r_sh[2] :
                    (w_nidx == 3'd3) ? r_sh[3] : r_sh[4];

    // next-state and next-output logic; column and row change on the same edge
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_sel   = r_sel;
        w_row   = r_row;
        w_fs    = 1'b0;
        w_cap   = 1'b0;
        if (!enable) begin
            w_state = IDLE;
            w_cnt   = '0;
            w_idx   = 3'd0;
            w_sel   = 5'b00000;
            w_row   = 7'h7F;
        end else if (r_state == IDLE) begin
            w_state = NOBLANK ? DRIVE : BLANK;
            w_cnt   = '0;
            w_idx   = 3'd0;
            w_sel   = 5'b00001;
            w_row   = NOBLANK ? col_0 : 7'h7F;
            w_fs    = 1'b1;
            w_cap   = 1'b1;
        end else if (r_cnt == LAST) begin
            w_state = NOBLANK ? DRIVE : BLANK;
            w_cnt   = '0;
            w_idx   = w_nidx;
            w_sel   = w_wrap ? 5'b00001 : {r_sel[3:0], 1'b0};
            w_row   = NOBLANK ? w_nxt : 7'h7F;
            w_fs    = w_wrap;
            w_cap   = w_wrap;
        end else begin
            w_cnt = r_cnt + CW'(1);
            if (r_state == BLANK && r_cnt == BLAST) begin
                w_state = DRIVE;
                w_row   = w_cur;
            end
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_sel   <= 5'b00000;
            r_row   <= 7'h7F;
            r_fs    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_sel   <= w_sel;
            r_row   <= w_row;
            r_fs    <= w_fs;
        end
    end

    // shadow patterns reload only at frame start so a frame never tears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) r_sh[i] <= 7'h7F;
        end else if (w_cap) begin
            r_sh[0] <= col_0;
            r_sh[1] <= col_1;
            r_sh[2] <= col_2;
            r_sh[3] <= col_3;
            r_sh[4] <= col_4;
        end
    end

    assign col_sel     = r_sel;
    assign row_n       = r_row;
    assign col_idx     = r_idx;
    assign frame_start = r_fs;
endmodule

// File: tb/tb_matrix_column_scanner.sv
// tb_matrix_column_scanner: randomized self-checking bench against a time-based scan model
module tb_matrix_column_scanner;
    localparam int CD    = 10;
    localparam int FRAME = 5 * CD;
    localparam logic [15:0] RST = {5'd0, 7'h7F, 3'd0, 1'b0};

    logic       clk, reset, enable;
    logic [6:0] col_0, col_1, col_2, col_3, col_4;
    logic [4:0] sel_a, sel_b;
    logic [6:0] row_a, row_b;
    logic [2:0] idx_a, idx_b;
    logic       fs_a, fs_b;
    int         checks = 0;
    int         errors = 0;

    logic       m_on = 1'b0;
    int         m_t  = 0;
    logic [6:0] m_sh [5];

    matrix_column_scanner #(.CLK_DIV(CD), .BLANK_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .enable(enable),
        .col_0(col_0), .col_1(col_1), .col_2(col_2), .col_3(col_3), .col_4(col_4),
        .col_sel(sel_a), .row_n(row_a), .col_idx(idx_a), .frame_start(fs_a));

    matrix_column_scanner #(.CLK_DIV(CD), .BLANK_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable),
        .col_0(col_0), .col_1(col_1), .col_2(col_2), .col_3(col_3), .col_4(col_4),
        .col_sel(sel_b), .row_n(row_b), .col_idx(idx_b), .frame_start(fs_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: time since enable determines column and phase; patterns latched every FRAME cycles
    always @(posedge clk or posedge reset) begin
        if (reset || !enable) begin
            m_on <= 1'b0;
        end else begin
            m_on <= 1'b1;
            m_t  <= m_on ? m_t + 1 : 0;
            if (!m_on || ((m_t + 1) % FRAME) == 0) begin
                m_sh[0] <= col_0;
                m_sh[1] <= col_1;
                m_sh[2] <= col_2;
                m_sh[3] <= col_3;
                m_sh[4] <= col_4;
            end
        end
    end

    function automatic logic [15:0] expv(input int b);
        int slot, ofs;
        if (!m_on) return RST;
        slot = (m_t / CD) % 5;
        ofs  = m_t % CD;
        return {5'(1 << slot), (ofs < b) ? 7'h7F : m_sh[slot], 3'(slot), (m_t % FRAME) == 0};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        col_4 = 7'b1001111; col_3 = 7'b0000011; col_2 = 7'b0000001;
        col_1 = 7'b0000011; col_0 = 7'b1001111;
        repeat (3) @(negedge clk);
        checks++;
        if ({sel_a, row_a, idx_a, fs_a} !== RST) begin
            errors++; $display("FAIL reset_a got=%h exp=%h", {sel_a, row_a, idx_a, fs_a}, RST);
        end
        checks++;
        if ({sel_b, row_b, idx_b, fs_b} !== RST) begin
            errors++; $display("FAIL reset_b got=%h exp=%h", {sel_b, row_b, idx_b, fs_b}, RST);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({sel_a, row_a, idx_a, fs_a} !== RST) begin
            errors++; $display("FAIL idle_disabled got=%h exp=%h", {sel_a, row_a, idx_a, fs_a}, RST);
        end
    endtask

    task automatic test_first_slot();
        logic [15:0] ea, eb;
        enable = 1'b1;
        for (int k = 0; k <= CD; k++) begin
            @(negedge clk);
            ea = {(k < CD) ? 5'b00001 : 5'b00010, (k < 2 || k == CD) ? 7'h7F : 7'b1001111,
                  (k < CD) ? 3'd0 : 3'd1, k == 0};
            eb = {(k < CD) ? 5'b00001 : 5'b00010, (k < CD) ? 7'b1001111 : 7'b0000011,
                  (k < CD) ? 3'd0 : 3'd1, k == 0};
            checks++;
            if ({sel_a, row_a, idx_a, fs_a} !== ea) begin
                errors++; $display("FAIL first_slot_a k=%0d got=%h exp=%h", k, {sel_a, row_a, idx_a, fs_a}, ea);
            end
            checks++;
            if ({sel_b, row_b, idx_b, fs_b} !== eb) begin
                errors++; $display("FAIL first_slot_b k=%0d got=%h exp=%h", k, {sel_b, row_b, idx_b, fs_b}, eb);
            end
        end
    endtask

    task automatic test_scan();
        int last = -1;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            checks++;
            if ({sel_a, row_a, idx_a, fs_a} !== expv(2)) begin
                errors++; $display("FAIL scan_a t=%0t got=%h exp=%h", $time, {sel_a, row_a, idx_a, fs_a}, expv(2));
            end
            checks++;
            if ({sel_b, row_b, idx_b, fs_b} !== expv(0)) begin
                errors++; $display("FAIL scan_b t=%0t got=%h exp=%h", $time, {sel_b, row_b, idx_b, fs_b}, expv(0));
            end
            checks++;
            if (!$onehot0(sel_a) || !$onehot0(sel_b)) begin
                errors++; $display("FAIL onehot got=%b/%b exp=onehot0", sel_a, sel_b);
            end
            if (fs_a) begin
                if (last >= 0) begin
                    checks++;
                    if (c - last != FRAME) begin
                        errors++; $display("FAIL frame_period got=%0d exp=%0d", c - last, FRAME);
                    end
                end
                last = c;
            end
        end
    endtask

    task automatic test_no_tearing();
        int frames = 0;
        for (int i = 0; i < 200 && idx_a != 3'd1; i++) @(negedge clk);
        checks++;
        if (idx_a != 3'd1) begin
            errors++; $display("FAIL wait_col1 got=%0d exp=1", idx_a);
        end
        col_2 = 7'b0000000;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (fs_a) frames++;
            checks++;
            if ({sel_a, row_a, idx_a, fs_a} !== expv(2)) begin
                errors++; $display("FAIL tear_a t=%0t got=%h exp=%h", $time, {sel_a, row_a, idx_a, fs_a}, expv(2));
            end
            if (idx_a == 3'd2 && row_a != 7'h7F && frames < 2) begin
                checks++;
                if (row_a !== (frames == 0 ? 7'b0000001 : 7'b0000000)) begin
                    errors++; $display("FAIL tear_col2 frame=%0d got=%b", frames, row_a);
                end
            end
        end
    endtask

    task automatic test_disable();
        logic [15:0] eb;
        for (int i = 0; i < 200 && !(idx_a == 3'd3 && row_a != 7'h7F); i++) @(negedge clk);
        checks++;
        if (!(idx_a == 3'd3 && row_a != 7'h7F)) begin
            errors++; $display("FAIL wait_col3_drive got=%0d/%h exp=3/drive", idx_a, row_a);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({sel_a, row_a, idx_a, fs_a} !== RST) begin
            errors++; $display("FAIL disable_a got=%h exp=%h", {sel_a, row_a, idx_a, fs_a}, RST);
        end
        checks++;
        if ({sel_b, row_b, idx_b, fs_b} !== RST) begin
            errors++; $display("FAIL disable_b got=%h exp=%h", {sel_b, row_b, idx_b, fs_b}, RST);
        end
        col_0 = 7'b0101010;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if ({sel_a, row_a, idx_a, fs_a} !== {5'b00001, 7'h7F, 3'd0, 1'b1}) begin
            errors++; $display("FAIL reenable_a got=%h", {sel_a, row_a, idx_a, fs_a});
        end
        eb = {5'b00001, 7'b0101010, 3'd0, 1'b1};
        checks++;
        if ({sel_b, row_b, idx_b, fs_b} !== eb) begin
            errors++; $display("FAIL reenable_b got=%h exp=%h", {sel_b, row_b, idx_b, fs_b}, eb);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            checks++;
            if ({sel_a, row_a, idx_a, fs_a} !== expv(2)) begin
                errors++; $display("FAIL rand_a t=%0t got=%h exp=%h", $time, {sel_a, row_a, idx_a, fs_a}, expv(2));
            end
            checks++;
            if ({sel_b, row_b, idx_b, fs_b} !== expv(0)) begin
                errors++; $display("FAIL rand_b t=%0t got=%h exp=%h", $time, {sel_b, row_b, idx_b, fs_b}, expv(0));
            end
            checks++;
            if (!$onehot0(sel_a) || !$onehot0(sel_b)) begin
                errors++; $display("FAIL rand_onehot got=%b/%b exp=onehot0", sel_a, sel_b);
            end
            case ($urandom_range(0, 7))
                0: col_0 = 7'($urandom);
                1: col_1 = 7'($urandom);
                2: col_2 = 7'($urandom);
                3: col_3 = 7'($urandom);
                4: col_4 = 7'($urandom);
                default: ;
            endcase
            if (!enable) enable = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 149) == 0) enable = 1'b0;
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 200 && idx_a != 3'd4; i++) @(negedge clk);
        checks++;
        if (idx_a != 3'd4) begin
            errors++; $display("FAIL wait_col4 got=%0d exp=4", idx_a);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({sel_a, row_a, idx_a, fs_a} !== RST) begin
            errors++; $display("FAIL async_reset_a got=%h exp=%h", {sel_a, row_a, idx_a, fs_a}, RST);
        end
        checks++;
        if ({sel_b, row_b, idx_b, fs_b} !== RST) begin
            errors++; $display("FAIL async_reset_b got=%h exp=%h", {sel_b, row_b, idx_b, fs_b}, RST);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({sel_a, row_a, idx_a, fs_a} !== RST) begin
            errors++; $display("FAIL reset_release got=%h exp=%h", {sel_a, row_a, idx_a, fs_a}, RST);
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            checks++;
            if ({sel_a, row_a, idx_a, fs_a} !== expv(2)) begin
                errors++; $display("FAIL post_reset_a t=%0t got=%h exp=%h", $time, {sel_a, row_a, idx_a, fs_a}, expv(2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_slot();
        test_scan();
        test_no_tearing();
        test_disable();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_column_scanner.md
Name: matrix_column_scanner

Overview:
- Time-multiplexed driver for the 5x7 LED matrix, directly downstream of the image selector.
- Takes the five 7-bit column patterns, snapshots them once per frame, and scans columns 0..4 one at a time.
- Each column slot starts with a short row-blanking interval to suppress ghosting.
- Outputs go straight to the matrix pins: column select is one-hot active-high; rows are active-low. Pattern bit 0 means the LED is lit.

Parameters:
- CLK_DIV, 50000, clock cycles per column slot (≥2); 50 MHz gives 1 kHz column rate and 200 Hz frame rate.
- BLANK_CYCLES, 8, cycles at the start of each slot with rows forced off (0 ≤ BLANK_CYCLES < CLK_DIV).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  scan enable; low blanks the matrix
- col_0  input  7  pattern for column 0 (bit i = row i, 0 = lit)
- col_1  input  7  pattern for column 1
- col_2  input  7  pattern for column 2
- col_3  input  7  pattern for column 3
- col_4  input  7  pattern for column 4
- col_sel  output  5  one-hot column drive, active-high
- row_n  output  7  row drive, active-low
- col_idx  output  3  index of the active column (0..4)
- frame_start  output  1  one-cycle pulse when column 0 begins and patterns are captured

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- All outputs are registered. On reset:
  - col_sel = 5'b00000, row_n = 7'h7F, col_idx = 0, frame_start = 0.
  - Slot counter = 0; shadow patterns = all 7'h7F; state = IDLE.
- States:
  - IDLE: col_sel = 0, row_n = 7'h7F.
  - BLANK: col_sel active, row_n = 7'h7F.
  - DRIVE: col_sel active, row_n = shadow[col_idx].
- IDLE → first slot: on the edge where enable is sampled high in IDLE:
  - col_idx ← 0, col_sel ← 00001, slot counter ← 0.
  - Shadow ← {col_4..col_0}; frame_start ← 1 for exactly that cycle.
  - State ← BLANK, or DRIVE when BLANK_CYCLES = 0.
- Slot counter: increments every cycle, 0..CLK_DIV-1. Width is clog2(CLK_DIV). It never exceeds CLK_DIV-1.
- BLANK → DRIVE: on the edge where counter = BLANK_CYCLES-1. row_n therefore stays 7'h7F for exactly BLANK_CYCLES cycles of each slot.
- End of slot (counter = CLK_DIV-1):
  - Counter ← 0; state ← BLANK (or DRIVE if BLANK_CYCLES = 0).
  - col_idx increments and col_sel shifts left. col_sel and row_n change on the same edge, so the new column is never lit with the old pattern.
  - If col_idx = 4: wrap to 0, col_sel ← 00001, recapture shadow, pulse frame_start.
- Pattern capture: shadow updates only at frame start. Input changes mid-frame never take effect until the next frame, so there is no tearing.
- Disable: enable sampled low in any state → next edge goes to IDLE.
  - col_sel ← 0, row_n ← 7'h7F, col_idx ← 0, counter ← 0, frame_start ← 0.
  - Re-enable always restarts at column 0 with a fresh capture.
- Frame period: exactly 5·CLK_DIV cycles. frame_start pulses are spaced 5·CLK_DIV apart while enable stays high.
- Mid-operation reset: immediate return to reset values regardless of state. No pulse on release.
- Invariants: col_sel is one-hot or zero, never multi-hot. col_sel = 1<<col_idx whenever not IDLE.

Test Plan:
- CLK_DIV=10, BLANK_CYCLES=2; hold reset, then enable=1 → one cycle later col_sel=00001, frame_start=1 for 1 cycle, row_n=7F for 2 cycles, then row_n=col_0 for 8 cycles, then col_sel=00010.
- Static patterns col_4=7'b1001111, col_3=7'b0000011, col_2=7'b0000001, col_1=col_3, col_0=col_4 → DRIVE phases show 1001111, 0000011, 0000001, 0000011, 1001111 in order; frame_start every 50 cycles.
- Change col_2 to 7'b0000000 during the column 1 slot → current frame still shows 0000001 on column 2; next frame shows 0000000.
- Deassert enable during the column 3 DRIVE phase → next cycle col_sel=0, row_n=7F, col_idx=0; re-enable → restart at column 0 with frame_start.
- BLANK_CYCLES=0 → row_n equals the column pattern in every cycle of every slot; no all-7F cycle while enabled.
- Assert reset in the column 4 slot → col_sel=0, row_n=7F, frame_start=0 asynchronously. Throughout all runs col_sel is never multi-hot.
